// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package clk_div_pkg;

  localparam int unsigned DEF_RATIO_C = 6;

  // Channel-select width, never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // First count value at which the square wave is high: N - floor(N/2).
  function automatic logic [31:0] hi_thr(input logic [31:0] n);
    return n - (n >> 1);
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/pending ratio, and registered tick/square-wave outputs.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned DEF_RATIO = DEF_RATIO_C
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             wr,
  input  logic [CNT_W-1:0] ratio,
  input  logic             sync_clr,
  output logic             tick,
  output logic             clk_out,
  output logic             pend
);

  logic [CNT_W-1:0] cnt, act_ratio, pend_ratio;
  logic [CNT_W-1:0] cnt_d, act_d, pend_ratio_d, thr_d;
  logic             pend_d, tick_d, clk_d, wrap;

  always_comb begin
    cnt_d        = cnt;
    act_d        = act_ratio;
    pend_ratio_d = pend_ratio;
    pend_d       = pend;
    // A disabled channel (N=0) is treated as wrapping every cycle, so a pending ratio lands on the next edge.
    wrap = (act_ratio == '0) || (cnt == act_ratio - CNT_W'(1));
    if (sync_clr || wrap) begin
      cnt_d = '0;
      if (pend) begin
        act_d  = pend_ratio;
        pend_d = 1'b0;
      end
    end else begin
      cnt_d = cnt + CNT_W'(1);
    end
    if (wr) begin
      pend_ratio_d = ratio;
      pend_d       = 1'b1;
    end
    thr_d  = CNT_W'(hi_thr(32'(act_d)));
    tick_d = !sync_clr && (act_d != '0) && (cnt_d == act_d - CNT_W'(1));
    clk_d  = !sync_clr && (act_d != '0) && (cnt_d >= thr_d);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt        <= '0;
      act_ratio  <= CNT_W'(DEF_RATIO);
      pend_ratio <= '0;
      pend       <= 1'b0;
      tick       <= 1'b0;
      clk_out    <= 1'b0;
    end else begin
      cnt        <= cnt_d;
      act_ratio  <= act_d;
      pend_ratio <= pend_ratio_d;
      pend       <= pend_d;
      tick       <= tick_d;
      clk_out    <= clk_d;
    end
  end

endmodule

// File: rtl/clk_divider_prog.sv
// Multi-channel run-time programmable integer clock divider with global phase align.
module clk_divider_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned CH_NUM    = 4,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned DEF_RATIO = DEF_RATIO_C,
  parameter int unsigned CH_W      = sel_width(CH_NUM)
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_ratio,
  input  logic              sync_clr,
  output logic [CH_NUM-1:0] tick,
  output logic [CH_NUM-1:0] clk_out,
  output logic [CH_NUM-1:0] pend
);

  logic [CH_NUM-1:0] wr_sel;

  // Selects at or beyond CH_NUM match no channel and are dropped.
  always_comb begin
    wr_sel = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      wr_sel[i] = cfg_wr && (cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_chan
    clk_div_chan #(
      .CNT_W    (CNT_W),
      .DEF_RATIO(DEF_RATIO)
    ) u_chan (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .wr       (wr_sel[g]),
      .ratio    (cfg_ratio),
      .sync_clr (sync_clr),
      .tick     (tick[g]),
      .clk_out  (clk_out[g]),
      .pend     (pend[g])
    );
  end

endmodule
